dot_stream_ctrl: RTL
====================

Name: dot_stream_ctrl

Overview:
Sequencer for the 16-lane 32-bit multiply-add tree. It accepts a job descriptor giving a vector length in 512-bit lines, then streams that many line pairs through the tree with a valid/ready handshake. It accumulates the per-line 32-bit results and returns one 32-bit dot product per job. It sits between the CCI-E read-response path and the result-writeback logic of the accelerator.

Parameters:
LEN_W, 16, width of the job length field (max job = 2^LEN_W - 1 lines)
LANES, 16, number of 32-bit lanes per 512-bit line (fixed at 16; tied to the tree width)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  job descriptor valid
start_ready  output  1  controller can accept a job
start_len  input  LEN_W  number of line pairs in the job
in_valid  input  1  operand line pair valid
in_ready  output  1  controller accepts a line pair this cycle
in_a  input  512  operand line A, lane i = bits [32i+31:32i]
in_b  input  512  operand line B, same lane packing
res_valid  output  1  dot product result valid
res_ready  input  1  downstream accepts result
res_data  output  32  dot product result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high and overrides all other inputs. It forces state=IDLE, acc=0, remaining=0, stage_valid=0, res_valid=0, res_data=0, in_ready=0 and busy=0. start_ready=1 from the cycle after reset deasserts.
- Reset mid-job aborts the job. Partial sums are discarded and no result is emitted.
- Line math: line_sum = sum over 16 lanes of (a_i*b_i mod 2^32), mod 2^32. Computed combinationally from in_a/in_b. All arithmetic wraps at 32 bits, with no saturation and no overflow flag.
- Pipeline:
  - Stage 1: on an accepted beat (in_valid && in_ready), line_sum is registered into stage_sum and stage_valid=1. Otherwise stage_valid=0.
  - Stage 2: when stage_valid=1, acc <= acc + stage_sum.
- States:
  - IDLE: start_ready=1, in_ready=0. A start handshake loads remaining=start_len and clears acc.
    - If start_len==0: go to DONE with res_data=0.
    - Otherwise go to RUN.
  - RUN: in_ready=1 while remaining!=0. Each accepted beat decrements remaining. When the beat with remaining==1 is accepted, go to DRAIN. Bubbles (in_valid=0) are allowed anywhere; state and remaining hold.
  - DRAIN: in_ready=0. Wait for the final stage_valid to be added into acc. On the cycle the last add is made, res_data <= acc + stage_sum and res_valid <= 1, then go to DONE.
  - DONE: res_valid=1 with res_data held stable until res_ready. On res_valid && res_ready go to IDLE, drop res_valid, keep res_data as last value.
- Latency: last beat accepted at cycle T gives res_valid high at T+2. Back-to-back beats sustain 1 line/cycle.
- start_ready=0 in RUN, DRAIN and DONE. A start_valid there is not consumed and start_len is ignored.
- Lines with in_valid asserted outside RUN are not consumed (in_ready=0).
- The cycle after DONE→IDLE accepts a new job. The DONE→IDLE transition and a new start in that same cycle are not simultaneous, because start_ready=0 in DONE.
- Max job start_len = 2^LEN_W-1 completes normally.
- The remaining counter never underflows. in_ready is gated by remaining!=0.

Test Plan:
- Single line: len=1, all lanes a=2 and b=3 → one beat accepted, res_data=96 (16*6), res_valid exactly 2 cycles after the beat; hold res_ready=0 for 5 cycles → res_data stable at 96.
- Multi-line with bubbles: len=4, lane i of line k has a=i+1, b=k+1, random in_valid gaps → res_data=136*(1+2+3+4)=1360; exactly 4 beats consumed, and a 5th offered line sees in_ready=0.
- Wrap-around: len=2, all lanes a=b=0xFFFF_FFFF (product mod 2^32 = 1) then a=0x0001_0000, b=0x0001_0000 (product 0) → res_data=16. Also len=1 with lane0 a=0x8000_0000, b=2, others 0 → res_data=0.
- Zero length: start_len=0 → no in_ready pulse, res_valid the cycle after the start, res_data=0, then start_ready=1 after the res handshake.
- Reset mid-job: len=8, reset after 3 beats → next cycle busy=0, res_valid=0, start_ready=1; a following len=1 job (a=b=1) returns 16, not a stale partial sum.
- Back-to-back jobs: len=3 then len=2 with res_ready tied 1, all lanes a=b=1 → results 48 then 32; start is rejected while busy; throughput is 1 beat/cycle within each job.

Source files
------------

// File: rtl/dot_stream_ctrl.sv
// Dot-product stream sequencer for the 16-lane 32-bit multiply-add tree.
//
// A job descriptor (start_len line pairs) is accepted in idle. The controller
// then takes that many 512-bit operand line pairs, reduces each pair to a
// 32-bit line sum, accumulates the line sums and returns one 32-bit dot
// product. All arithmetic wraps modulo 2^32.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   start_valid/start_ready       job descriptor handshake, start_len = lines
//   in_valid/in_ready, in_a/in_b  operand line pair handshake (lane i = [32i+31:32i])
//   res_valid/res_ready, res_data dot product result handshake
//   busy                          high whenever a job is in progress
module dot_stream_ctrl #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned LANES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [LEN_W-1:0]      start_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_a,
    input  logic [LANES*32-1:0]   in_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        stage_sum_q, stage_sum_d;
    logic               stage_valid_q, stage_valid_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_data_q, res_data_d;

    logic [31:0]        line_sum;
    logic [31:0]        lane_prod;
    logic               beat;

    // Combinational multiply-add tree: products and sum both wrap at 32 bits.
    always_comb begin
        line_sum  = '0;
        lane_prod = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_prod = in_a[32*i +: 32] * in_b[32*i +: 32];
            line_sum  = line_sum + lane_prod;
        end
    end

    always_comb begin
        // Held low during reset so no job can be taken while reset is asserted.
        start_ready = (state_q == StIdle) && !reset;
        // Gating on remaining keeps the counter from ever underflowing.
        in_ready    = (state_q == StRun) && (remaining_q != '0);
        busy        = (state_q != StIdle);
        beat        = in_valid && in_ready;
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        acc_d         = stage_valid_q ? (acc_q + stage_sum_q) : acc_q;
        stage_valid_d = beat;
        stage_sum_d   = beat ? line_sum : stage_sum_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid && start_ready) begin
                    remaining_d = start_len;
                    acc_d       = '0;
                    if (start_len == '0) begin
                        // Empty job: result is ready the very next cycle.
                        state_d     = StDone;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (beat) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Fold the final line sum straight into the result register.
                if (stage_valid_q) begin
                    res_data_d  = acc_q + stage_sum_q;
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            remaining_q   <= '0;
            acc_q         <= '0;
            stage_sum_q   <= '0;
            stage_valid_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            acc_q         <= acc_d;
            stage_sum_q   <= stage_sum_d;
            stage_valid_q <= stage_valid_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule
